// File: rtl/prog_loader.sv
// Program-RAM loader: accepts an image as a byte stream, writes it to sequential
// RAM addresses with the CPU halted, then checks a trailing checksum byte.
module prog_loader #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int WIDTH         = 8,
  parameter int MEMORY_SIZE   = 1 << ADDRESS_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             rx_ready,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data,
  output logic             ram_write_enable,
  output logic             cpu_halt,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_SIZE - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0]         data_q,  data_d;
  logic [WIDTH-1:0]         sum_q,   sum_d;
  logic                     done_q,  done_d;
  logic                     error_q, error_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // rx_ready, cpu_halt and the write strobe are decoded from state alone,
  // so rx_ready never combinationally depends on rx_valid.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    sum_d            = sum_q;
    done_d           = done_q;
    error_d          = error_q;
    rx_ready         = 1'b0;
    cpu_halt         = 1'b0;
    ram_write_enable = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        rx_ready = 1'b1;
        cpu_halt = 1'b1;
        if (rx_valid) begin
          data_d  = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        cpu_halt         = 1'b1;
        ram_write_enable = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + ADDRESS_WIDTH'(1);
          state_d = S_RECV;
        end
      end

      S_CHECK: begin
        rx_ready = 1'b1;
        cpu_halt = 1'b1;
        if (rx_valid) begin
          error_d = (rx_data != sum_q);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr = WIDTH'(addr_q);
  assign ram_data = data_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
